// File: rtl/condicionador_botoes.sv
// Button conditioner: per-channel 2-flop synchronizer and debounce FSM, one-shot
// press pulses gated by enable, and a saturating count of accepted presses.
module condicionador_botoes #(
    parameter int N_BOTOES        = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                enable,
    input  logic                limpar_contagem,
    output logic [N_BOTOES-1:0] botoes_pulso,
    output logic [N_BOTOES-1:0] botoes_estavel,
    output logic                algum_pulso,
    output logic [15:0]         contagem_jogadas
);

    localparam int            CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 2);
    localparam int            PW     = $clog2(N_BOTOES + 1);

    typedef enum logic [1:0] {
        SOLTO,
        CONF_PRESS,
        PRESSIONADO,
        CONF_SOLTA
    } estado_t;

    logic [N_BOTOES-1:0] r_sync1;
    logic [N_BOTOES-1:0] r_sync2;
    logic [N_BOTOES-1:0] w_pulso;
    logic [N_BOTOES-1:0] w_estavel;
    logic [PW-1:0]       w_popcount;
    logic [16:0]         w_soma;
    logic [15:0]         r_contagem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= botoes_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The stable level is registered with the state so it is 1 exactly in PRESSIONADO/CONF_SOLTA;
    // the pulse only fires on the CONF_PRESS -> PRESSIONADO edge, so a bounce back from
    // CONF_SOLTA or enable rising later while held never produces one.
    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        estado_t       r_estado;
        logic [CW-1:0] r_contador;
        logic          r_pulso;
        logic          r_estavel;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_estado   <= SOLTO;
                r_contador <= '0;
                r_pulso    <= 1'b0;
                r_estavel  <= 1'b0;
            end else begin
                r_pulso <= 1'b0;
                case (r_estado)
                    SOLTO: begin
                        if (r_sync2[i]) begin
                            r_estado   <= CONF_PRESS;
                            r_contador <= '0;
                        end
                    end
                    CONF_PRESS: begin
                        if (!r_sync2[i]) begin
                            r_estado <= SOLTO;
                        end else if (r_contador == LIMITE) begin
                            r_estado  <= PRESSIONADO;
                            r_estavel <= 1'b1;
                            r_pulso   <= enable;
                        end else begin
                            r_contador <= r_contador + CW'(1);
                        end
                    end
                    PRESSIONADO: begin
                        if (!r_sync2[i]) begin
                            r_estado   <= CONF_SOLTA;
                            r_contador <= '0;
                        end
                    end
                    CONF_SOLTA: begin
                        if (r_sync2[i]) begin
                            r_estado <= PRESSIONADO;
                        end else if (r_contador == LIMITE) begin
                            r_estado  <= SOLTO;
                            r_estavel <= 1'b0;
                        end else begin
                            r_contador <= r_contador + CW'(1);
                        end
                    end
                    default: begin
                        r_estado  <= SOLTO;
                        r_estavel <= 1'b0;
                    end
                endcase
            end
        end

        assign w_pulso[i]   = r_pulso;
        assign w_estavel[i] = r_estavel;
    end

    always_comb begin
        w_popcount = '0;
        for (int k = 0; k < N_BOTOES; k++) begin
            w_popcount = w_popcount + PW'(w_pulso[k]);
        end
    end

    assign w_soma = {1'b0, r_contagem} + 17'(w_popcount);

    // Clear wins over a same-cycle increment; the carry bit signals saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_contagem <= '0;
        end else if (limpar_contagem) begin
            r_contagem <= '0;
        end else if (w_soma[16]) begin
            r_contagem <= 16'hFFFF;
        end else begin
            r_contagem <= w_soma[15:0];
        end
    end

    assign botoes_pulso     = w_pulso;
    assign botoes_estavel   = w_estavel;
    assign algum_pulso      = |w_pulso;
    assign contagem_jogadas = r_contagem;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed steps with a pulse scoreboard, plus a
// second fast instance (16 channels, debounce 2) used to reach counter saturation.
module tb_condicionador_botoes;

    localparam int NB = 8;
    localparam int DB = 4;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } pulseExp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] botoes_raw;
    logic          enable;
    logic          limpar_contagem;
    logic [NB-1:0] botoes_pulso;
    logic [NB-1:0] botoes_estavel;
    logic          algum_pulso;
    logic [15:0]   contagem_jogadas;

    logic [15:0]   satRaw;
    logic          satLimpar;
    logic [15:0]   satPulso;
    logic [15:0]   satEstavel;
    logic          satAlgum;
    logic [15:0]   satCont;

    int        checks = 0;
    int        errors = 0;
    int        edgeCnt = 0;
    pulseExp_t expQ[$];

    condicionador_botoes #(.N_BOTOES(NB), .DEBOUNCE_CYCLES(DB)) dut (
        .clk              (clk),
        .rst              (rst),
        .botoes_raw       (botoes_raw),
        .enable           (enable),
        .limpar_contagem  (limpar_contagem),
        .botoes_pulso     (botoes_pulso),
        .botoes_estavel   (botoes_estavel),
        .algum_pulso      (algum_pulso),
        .contagem_jogadas (contagem_jogadas)
    );

    condicionador_botoes #(.N_BOTOES(16), .DEBOUNCE_CYCLES(2)) dutSat (
        .clk              (clk),
        .rst              (rst),
        .botoes_raw       (satRaw),
        .enable           (enable),
        .limpar_contagem  (satLimpar),
        .botoes_pulso     (satPulso),
        .botoes_estavel   (satEstavel),
        .algum_pulso      (satAlgum),
        .contagem_jogadas (satCont)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    // A raw change driven now is first sampled at the next edge N; its pulse belongs to cycle N+2+DB.
    task automatic applyStimulus(input logic [7:0] raw, input logic [7:0] expPulse);
        pulseExp_t e;
        botoes_raw = raw;
        if (expPulse != 8'h00) begin
            e.cyc = edgeCnt + 1 + 2 + DB;
            e.val = expPulse;
            expQ.push_back(e);
        end
    endtask

    // Cycle label at a negedge is the edge that closes the current cycle.
    always @(negedge clk) begin
        logic [7:0] expP;
        int         nowCyc;
        nowCyc = edgeCnt + 1;
        expP   = 8'h00;
        while (expQ.size() > 0 && expQ[0].cyc < nowCyc) begin
            checkOutput("pulse_missed_cycle", 16'(nowCyc), 16'(expQ[0].cyc));
            expQ.delete(0);
        end
        if (expQ.size() > 0 && expQ[0].cyc == nowCyc) begin
            expP = expQ[0].val;
            expQ.delete(0);
        end
        checkOutput("botoes_pulso", 16'(botoes_pulso), 16'(expP));
        checkOutput("algum_pulso", 16'(algum_pulso), 16'(|expP));
    end

    initial begin
        rst             = 1'b1;
        botoes_raw      = '0;
        enable          = 1'b1;
        limpar_contagem = 1'b0;
        satRaw          = '0;
        satLimpar       = 1'b0;

        waitCycles(3);
        checkOutput("reset_pulso", 16'(botoes_pulso), 16'h0);
        checkOutput("reset_estavel", 16'(botoes_estavel), 16'h0);
        checkOutput("reset_algum", 16'(algum_pulso), 16'h0);
        checkOutput("reset_contagem", contagem_jogadas, 16'h0);
        rst = 1'b0;

        // Clean press sampled at edge 10, pulse expected in cycle 16.
        while (edgeCnt < 9) tick();
        applyStimulus(8'h01, 8'h01);
        waitCycles(10);
        checkOutput("clean_contagem", contagem_jogadas, 16'd1);
        checkOutput("clean_estavel", 16'(botoes_estavel), 16'h01);
        applyStimulus(8'h00, 8'h00);
        waitCycles(5);
        checkOutput("release_estavel_still_high", 16'(botoes_estavel), 16'h01);
        tick();
        checkOutput("release_estavel_low", 16'(botoes_estavel), 16'h00);

        // Bounce on channel 3.
        applyStimulus(8'h08, 8'h00);
        tick();
        applyStimulus(8'h00, 8'h00);
        tick();
        applyStimulus(8'h08, 8'h00);
        tick();
        applyStimulus(8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bounce_estavel", 16'(botoes_estavel), 16'h00);
        end

        // Simultaneous presses held long: exactly one pulse for both channels.
        applyStimulus(8'h81, 8'h81);
        waitCycles(30);
        checkOutput("simul_contagem", contagem_jogadas, 16'd3);
        checkOutput("simul_estavel", 16'(botoes_estavel), 16'h81);
        applyStimulus(8'h00, 8'h00);
        waitCycles(10);
        checkOutput("simul_release", 16'(botoes_estavel), 16'h00);

        // Press accepted while masked, enable raised while held.
        enable = 1'b0;
        applyStimulus(8'h04, 8'h00);
        waitCycles(10);
        checkOutput("mask_estavel", 16'(botoes_estavel), 16'h04);
        enable = 1'b1;
        waitCycles(10);
        checkOutput("mask_contagem", contagem_jogadas, 16'd3);
        applyStimulus(8'h00, 8'h00);
        waitCycles(10);
        applyStimulus(8'h04, 8'h04);
        waitCycles(10);
        checkOutput("unmask_contagem", contagem_jogadas, 16'd4);
        applyStimulus(8'h00, 8'h00);
        waitCycles(10);

        // Channel 1 held and accepted, then reset while channel 5 is mid-debounce.
        applyStimulus(8'h02, 8'h02);
        waitCycles(10);
        checkOutput("pre_reset_contagem", contagem_jogadas, 16'd5);
        checkOutput("pre_reset_estavel", 16'(botoes_estavel), 16'h02);
        applyStimulus(8'h22, 8'h00);
        waitCycles(3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pulso", 16'(botoes_pulso), 16'h0);
        checkOutput("async_rst_estavel", 16'(botoes_estavel), 16'h0);
        checkOutput("async_rst_algum", 16'(algum_pulso), 16'h0);
        checkOutput("async_rst_contagem", contagem_jogadas, 16'h0);
        tick();
        rst = 1'b0;
        applyStimulus(8'h22, 8'h22);
        waitCycles(12);
        checkOutput("post_reset_contagem", contagem_jogadas, 16'd2);
        checkOutput("post_reset_estavel", 16'(botoes_estavel), 16'h22);
        applyStimulus(8'h00, 8'h00);
        waitCycles(10);

        limpar_contagem = 1'b1;
        tick();
        limpar_contagem = 1'b0;
        checkOutput("limpar_contagem", contagem_jogadas, 16'h0);

        // Saturation: 4095 rounds of 16 simultaneous presses reach 0xFFF0.
        for (int r = 0; r < 4095; r++) begin
            satRaw = 16'hFFFF;
            waitCycles(4);
            satRaw = 16'h0000;
            waitCycles(4);
        end
        checkOutput("sat_preload", satCont, 16'hFFF0);
        for (int r = 0; r < 2; r++) begin
            satRaw = 16'hFFFF;
            waitCycles(4);
            satRaw = 16'h0000;
            waitCycles(4);
            checkOutput("sat_hold", satCont, 16'hFFFF);
        end

        // Clear issued in the same cycle as a pulse.
        satRaw = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (satPulso != 16'h0) break;
        end
        checkOutput("sat_pulse_seen", satPulso, 16'h0001);
        satLimpar = 1'b1;
        tick();
        satLimpar = 1'b0;
        checkOutput("sat_clear_priority", satCont, 16'h0);
        satRaw = 16'h0000;
        waitCycles(4);
        satRaw = 16'h0001;
        waitCycles(8);
        checkOutput("sat_after_clear", satCont, 16'd1);
        satRaw = 16'h0000;
        waitCycles(4);

        checkOutput("scoreboard_empty", 16'(expQ.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter N_BOTOES, default 8, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); legal range 2..2^20.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 botoes_raw  input  N_BOTOES  raw, asynchronous, bouncing physical button levels; 1 = pressed.
REQ-006 enable  input  1  when 1, accepted presses produce pulses; when 0, pulses masked.
REQ-007 limpar_contagem  input  1  synchronous clear of contagem_jogadas.
REQ-008 botoes_pulso  output  N_BOTOES  one-cycle pulse per accepted press; drives the LED-matrix toggle inputs.
REQ-009 botoes_estavel  output  N_BOTOES  debounced level per channel.
REQ-010 algum_pulso  output  1  OR of botoes_pulso, same cycle.
REQ-011 contagem_jogadas  output  16  saturating count of accepted, unmasked presses.

Function
REQ-012 Each channel shall pass botoes_raw through a 2-flop synchronizer; sync[i] is the second flop output.
REQ-013 Each channel shall run an independent FSM with states SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLTA and a private counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-014 SOLTO: sync=1 -> CONF_PRESS, counter cleared to 0; otherwise stay.
REQ-015 CONF_PRESS: sync=0 -> SOLTO. sync=1 and counter=DEBOUNCE_CYCLES-2 -> PRESSIONADO. Otherwise counter+1.
REQ-016 PRESSIONADO: sync=0 -> CONF_SOLTA, counter cleared to 0; otherwise stay.
REQ-017 CONF_SOLTA: sync=1 -> PRESSIONADO, with no pulse. sync=0 and counter=DEBOUNCE_CYCLES-2 -> SOLTO. Otherwise counter+1.
REQ-018 botoes_estavel[i] shall be 1 exactly when the FSM is in PRESSIONADO or CONF_SOLTA.
REQ-019 botoes_pulso[i] shall be a registered output, 1 for exactly one cycle: the first cycle the FSM is in PRESSIONADO after leaving CONF_PRESS, gated by enable sampled on that same transition edge.
REQ-020 Latency: raw held high from the edge where it is first sampled (edge N) -> pulse visible in cycle N+2+DEBOUNCE_CYCLES; release shows the same latency on botoes_estavel falling.
REQ-021 A press accepted while enable=0 shall never produce a later pulse, even if enable rises while the button is still held.
REQ-022 A bounce shorter than DEBOUNCE_CYCLES shall produce no pulse and no change on botoes_estavel.
REQ-023 Simultaneous accepted presses on several channels shall pulse in the same cycle; contagem_jogadas shall increase by the number of set bits in botoes_pulso (popcount).
REQ-024 contagem_jogadas shall saturate at 0xFFFF and never wrap.
REQ-025 limpar_contagem=1 shall load 0 and takes priority over any increment in the same cycle.
REQ-026 Holding a button indefinitely shall yield exactly one pulse; a new pulse requires a full debounced release followed by a press.

Reset
REQ-027 rst=1 shall immediately force all FSMs to SOLTO, clear counters and synchronizers, and drive botoes_pulso=0, botoes_estavel=0, algum_pulso=0, contagem_jogadas=0.
REQ-028 rst asserted mid-debounce or mid-press shall abort the channel with no pulse; a button still held at reset release shall be re-debounced from SOLTO and then pulse once.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean press: raw[0]=1 from edge 10, enable=1 -> botoes_pulso=8'h01 only in cycle 16; algum_pulso=1 in cycle 16; contagem_jogadas=1 afterwards.
REQ-030 Bounce: raw[3] toggles 1,0,1,0 on consecutive cycles, then stays 0 -> no pulse, botoes_estavel[3]=0 throughout.
REQ-031 Simultaneous presses: raw=8'h81 on the same edge -> botoes_pulso=8'h81 in one cycle; contagem_jogadas increases by 2.
REQ-032 Masking: enable=0 during acceptance, then enable=1 while still held -> no pulse; after release and re-press, one pulse.
REQ-033 Saturation and clear: preload via 65535 presses (or force), one more press -> 0xFFFF held; limpar_contagem together with a pulse -> 0.
REQ-034 Reset mid-press: rst pulse while channel 5 is in CONF_PRESS with raw held -> all outputs 0 asynchronously; pulse in cycle R+2+4 after rst deasserts at edge R.
